// File: rtl/mat_stream_loader.sv
// Row-major element stream to SIZE_A x SIZE_B register matrix loader.
// Holds the assembled matrix with mat_valid until the consumer acks it.
module mat_stream_loader #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int N_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [N_BITS-1:0] in_data,
  input  logic                     in_last,
  output logic signed [N_BITS-1:0] mat_out [SIZE_A][SIZE_B],
  output logic                     mat_valid,
  input  logic                     mat_ack,
  output logic                     frame_err,
  output logic                     dbg_state
);

  localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(SIZE_A - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SIZE_B - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          accept;
  logic          at_final;

  // Handshake: an element transfers on a rising edge with in_valid && in_ready.
  // in_ready is registered and only high in FILL; the source holds data otherwise.
  assign accept    = in_valid && in_ready;
  assign at_final  = (row == ROW_LAST) && (col == COL_LAST);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      row       <= '0;
      col       <= '0;
      mat_valid <= 1'b0;
      frame_err <= 1'b0;
      in_ready  <= 1'b0;
      for (int r = 0; r < SIZE_A; r++) begin
        for (int c = 0; c < SIZE_B; c++) begin
          mat_out[r][c] <= '0;
        end
      end
    end else begin
      frame_err <= 1'b0;
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            mat_out[row][col] <= in_data;
            if (at_final && in_last) begin
              row       <= '0;
              col       <= '0;
              state     <= FULL;
              mat_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else if (at_final || in_last) begin
              // Misframed: keep the written element but restart the frame.
              row       <= '0;
              col       <= '0;
              frame_err <= 1'b1;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FULL: begin
          in_ready <= 1'b0;
          if (mat_ack) begin
            mat_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= FILL;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_stream_loader.sv
// Bench for mat_stream_loader at 2x2, 8-bit: framing, hold/ack, resets, gaps.
module tb_mat_stream_loader;

  localparam int SA = 2;
  localparam int SB = 2;
  localparam int NB = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [NB-1:0] in_data;
  logic                 in_last;
  logic signed [NB-1:0] mat_out [SA][SB];
  logic                 mat_valid;
  logic                 mat_ack;
  logic                 frame_err;
  logic                 dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int fe_count = 0;
  logic mv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] held;

  mat_stream_loader #(.SIZE_A(SA), .SIZE_B(SB), .N_BITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mat_out(mat_out),
    .mat_valid(mat_valid), .mat_ack(mat_ack), .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
    return {a, b, c, d};
  endfunction

  function automatic logic [31:0] flat();
    return {mat_out[0][0], mat_out[0][1], mat_out[1][0], mat_out[1][1]};
  endfunction

  // scoreboard: one expected matrix per rising edge of mat_valid
  always @(negedge clk) begin
    if (mat_valid && !mv_prev) begin
      if (exp_q.size() == 0) check("mat_unexpected", 32'd1, 32'd0);
      else check("mat_frame", flat(), exp_q.pop_front());
    end
    if (frame_err) begin
      fe_count++;
      check("frame_err_width", {31'd0, fe_prev}, 32'd0);
    end
    mv_prev = mat_valid;
    fe_prev = frame_err;
  end

  // driver: present one element, wait for in_ready, return #1 after the accept edge
  task automatic send(input logic [7:0] d, input logic l);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] d, input logic l);
    int g;
    g = $urandom_range(0, 3);
    for (int i = 0; i < g; i++) begin
      mat_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    mat_ack = 1'b0;
    send(d, l);
  endtask

  task automatic do_ack();
    mat_ack = 1'b1;
    @(posedge clk); #1;
    mat_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; mat_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mat_valid", {31'd0, mat_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_mat", flat(), 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    #2;
    check("ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {31'd0, in_ready}, 32'd1);

    // test 1: basic frame
    exp_q.push_back(pack4(8'd1, 8'd2, 8'd3, 8'hFC));
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    check("t1_valid_early", {31'd0, mat_valid}, 32'd0);
    send(8'hFC, 1'b1);
    check("t1_valid", {31'd0, mat_valid}, 32'd1);
    check("t1_ready", {31'd0, in_ready}, 32'd0);
    check("t1_mat", flat(), pack4(8'd1, 8'd2, 8'd3, 8'hFC));
    check("t1_state", {31'd0, dbg_state}, 32'd1);

    // test 2: hold while FULL with in_valid asserted
    held = flat();
    in_valid = 1'b1; in_data = 8'd99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t2_ready_hold", {31'd0, in_ready}, 32'd0);
      check("t2_valid_hold", {31'd0, mat_valid}, 32'd1);
    end
    check("t2_mat_hold", flat(), held);
    in_valid = 1'b0;
    do_ack();
    check("t2_valid_ack", {31'd0, mat_valid}, 32'd0);
    check("t2_ready_ack", {31'd0, in_ready}, 32'd1);

    // test 3: early last, then a good frame
    send(8'd5, 1'b0);
    send(8'd6, 1'b1);
    check("t3_frame_err", {31'd0, frame_err}, 32'd1);
    check("t3_valid", {31'd0, mat_valid}, 32'd0);
    @(posedge clk); #1;
    check("t3_frame_err_drop", {31'd0, frame_err}, 32'd0);
    exp_q.push_back(pack4(8'd7, 8'd8, 8'd9, 8'd10));
    send(8'd7, 1'b0); send(8'd8, 1'b0); send(8'd9, 1'b0); send(8'd10, 1'b1);
    check("t3_mat", flat(), pack4(8'd7, 8'd8, 8'd9, 8'd10));
    do_ack();

    // test 4: missing last, then a good frame lands at index 0
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    check("t4_frame_err", {31'd0, frame_err}, 32'd1);
    check("t4_valid", {31'd0, mat_valid}, 32'd0);
    check("t4_state", {31'd0, dbg_state}, 32'd0);
    exp_q.push_back(pack4(8'd11, 8'd12, 8'd13, 8'd14));
    send(8'd11, 1'b0); send(8'd12, 1'b0); send(8'd13, 1'b0); send(8'd14, 1'b1);
    check("t4_valid_after", {31'd0, mat_valid}, 32'd1);
    do_ack();
    check("fe_count", fe_count, 32'd2);

    // test 5: reset mid-fill, then reset while FULL
    send(8'd31, 1'b0); send(8'd32, 1'b0); send(8'd33, 1'b0);
    rst_n = 1'b0;
    #2;
    check("t5_rst_mat", flat(), 32'd0);
    check("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    check("t5_rst_valid", {31'd0, mat_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(pack4(8'hEB, 8'd22, 8'hE9, 8'd24));
    send(8'hEB, 1'b0); send(8'd22, 1'b0); send(8'hE9, 1'b0); send(8'd24, 1'b1);
    check("t5_valid", {31'd0, mat_valid}, 32'd1);
    check("t5_mat", flat(), pack4(8'hEB, 8'd22, 8'hE9, 8'd24));
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_full_rst_valid", {31'd0, mat_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // test 6: gaps and stray acks during FILL
    exp_q.push_back(pack4(8'd1, 8'd2, 8'd3, 8'hFC));
    send_gap(8'd1, 1'b0);
    send_gap(8'd2, 1'b0);
    send_gap(8'd3, 1'b0);
    send_gap(8'hFC, 1'b1);
    check("t6_valid", {31'd0, mat_valid}, 32'd1);
    check("t6_mat", flat(), pack4(8'd1, 8'd2, 8'd3, 8'hFC));
    repeat (2) @(posedge clk);
    #1;
    check("t6_hold", {31'd0, mat_valid}, 32'd1);
    do_ack();
    check("t6_ready", {31'd0, in_ready}, 32'd1);

    repeat (2) @(posedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
